// File: rtl/svc_uart_pkg.sv
// Shared UART definitions.
//   uart_rx_state_t : receiver FSM state encoding
//   uart_div()      : clocks per bit, rounded to nearest (also used by the TX side)
package svc_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  function automatic int unsigned uart_div(input int unsigned clock_freq,
                                           input int unsigned baud_rate);
    return (clock_freq + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/svc_sync_ff.sv
// N-flop synchroniser for a single asynchronous bit.
//   clk, rst_n : clock, async active-low reset (flops load RESET_VAL)
//   d          : asynchronous input
//   q          : synchronised output, N cycles of latency
module svc_sync_ff #(
  parameter int   N         = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  if (N < 2) begin : g_n_chk
    $fatal(1, "svc_sync_ff: N must be at least 2");
  end

  logic [N-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= {N{RESET_VAL}};
    else        ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];

endmodule

// File: rtl/svc_uart_rx.sv
// UART 8N1 receiver with a one-entry valid/ready output buffer.
//   clk, rst_n     : clock, async active-low reset
//   urx_rxd        : serial line (idle high), asynchronous to clk
//   urx_valid/data : received byte, held until urx_ready
//   urx_ready      : consumer accepts the byte
//   urx_frame_err  : 1-cycle pulse, stop bit sampled low
//   urx_overrun    : 1-cycle pulse, new byte dropped because buffer was full
module svc_uart_rx
  import svc_uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       urx_rxd,
  output logic       urx_valid,
  output logic [7:0] urx_data,
  input  logic       urx_ready,
  output logic       urx_frame_err,
  output logic       urx_overrun
);

  localparam int DIV  = int'(uart_div(CLOCK_FREQ, BAUD_RATE));
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

  if (DIV < 4) begin : g_div_chk
    $fatal(1, "svc_uart_rx: CLOCK_FREQ/BAUD_RATE gives fewer than 4 clocks per bit");
  end

  logic           rxd_s;
  uart_rx_state_t state;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shift;
  logic           tick;

  // Reset value 1 makes the line look idle straight after reset, so a
  // frame interrupted by reset cannot be mistaken for a new start bit.
  svc_sync_ff #(.N(2), .RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (urx_rxd),
    .q     (rxd_s)
  );

  assign tick = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift         <= '0;
      urx_valid     <= 1'b0;
      urx_data      <= '0;
      urx_frame_err <= 1'b0;
      urx_overrun   <= 1'b0;
    end else begin
      urx_frame_err <= 1'b0;
      urx_overrun   <= 1'b0;
      // Consumer handshake; a delivery in the same cycle overrides this.
      if (urx_valid && urx_ready) urx_valid <= 1'b0;
      if (!tick) cnt <= cnt - CW'(1);

      case (state)
        IDLE: begin
          if (!rxd_s) begin
            cnt   <= HALF_M1;
            state <= START;
          end
        end
        START: begin
          if (tick) begin
            if (!rxd_s) begin
              cnt     <= DIV_M1;
              bit_idx <= '0;
              state   <= DATA;
            end else begin
              state <= IDLE;  // start bit gone by mid-bit: glitch
            end
          end
        end
        DATA: begin
          if (tick) begin
            shift <= {rxd_s, shift[7:1]};  // LSB first
            cnt   <= DIV_M1;
            if (bit_idx == 3'd7) state   <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (tick) begin
            if (rxd_s) begin
              // Returning to IDLE here leaves half a bit of stop time to
              // catch a back-to-back start bit.
              state <= IDLE;
              if (!urx_valid || urx_ready) begin
                urx_data  <= shift;
                urx_valid <= 1'b1;
              end else begin
                urx_overrun <= 1'b1;
              end
            end else begin
              urx_frame_err <= 1'b1;
              state         <= WAIT_IDLE;  // break: one error, then wait for high
            end
          end
        end
        WAIT_IDLE: begin
          if (rxd_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_svc_uart_rx.sv
module tb_svc_uart_rx;
  import svc_uart_pkg::*;

  localparam int DIV = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       urx_rxd = 1'b1;
  logic       urx_ready = 1'b0;
  logic       urx_valid;
  logic [7:0] urx_data;
  logic       urx_frame_err;
  logic       urx_overrun;

  always #5 clk = ~clk;

  svc_uart_rx #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(115_200)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .urx_rxd       (urx_rxd),
    .urx_valid     (urx_valid),
    .urx_data      (urx_data),
    .urx_ready     (urx_ready),
    .urx_frame_err (urx_frame_err),
    .urx_overrun   (urx_overrun)
  );

  int         n_chk = 0;
  int         n_pass = 0;
  int         n_ferr = 0;
  int         n_ovr = 0;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  // Scoreboard: every accepted byte is popped and compared.
  always @(negedge clk) begin
    if (rst_n) begin
      if (urx_frame_err) n_ferr++;
      if (urx_overrun)   n_ovr++;
      if (urx_valid && urx_ready) begin
        if (exp_q.size() == 0) chk("spurious_byte", {31'd0, urx_valid}, 32'd0);
        else                   chk("byte", {24'd0, urx_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Line is left at the stop level so a low stop can run on into a break.
  task automatic send(input logic [7:0] b, input logic stop, input bit expect_it);
    if (expect_it) exp_q.push_back(b);
    urx_rxd = 1'b0;
    cyc(DIV);
    for (int i = 0; i < 8; i++) begin
      urx_rxd = b[i];
      cyc(DIV);
    end
    urx_rxd = stop;
    cyc(DIV);
  endtask

  initial begin
    string s;
    int    lat;
    int    ferr0;
    s   = "hello";
    lat = 0;

    urx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, urx_valid}, 32'd0);
    chk("rst_data", {24'd0, urx_data}, 32'd0);
    chk("rst_ferr", {31'd0, urx_frame_err}, 32'd0);
    chk("rst_ovr", {31'd0, urx_overrun}, 32'd0);
    rst_n = 1'b1;
    cyc(5);

    // Single byte with latency and pulse-width check
    fork
      send(8'h68, 1'b1, 1'b1);
      begin
        for (int n = 1; n <= 200; n++) begin
          @(posedge clk);
          #2;
          if (urx_valid) begin
            lat = n;
            break;
          end
        end
        chk("latency", lat, 88);
        @(posedge clk);
        #2;
        chk("valid_1cyc", {31'd0, urx_valid}, 32'd0);
      end
    join
    cyc(10);
    chk("single_ferr", n_ferr, 0);
    chk("single_ovr", n_ovr, 0);

    // "hello" back to back, always ready
    for (int i = 0; i < 5; i++) send(s[i], 1'b1, 1'b1);
    cyc(20);
    chk("hello_drain", exp_q.size(), 0);

    // "hello" again, frames every 200 cycles, ready pulsed once per 200 cycles
    urx_ready = 1'b0;
    fork
      for (int i = 0; i < 5; i++) begin
        send(s[i], 1'b1, 1'b1);
        cyc(200 - 10 * DIV);
      end
      repeat (5) begin
        cyc(199);
        urx_ready = 1'b1;
        cyc(1);
        urx_ready = 1'b0;
      end
    join
    cyc(20);
    chk("bp_drain", exp_q.size(), 0);
    chk("bp_ovr", n_ovr, 0);

    // Overrun: second byte dropped while first is held
    send(8'h41, 1'b1, 1'b1);
    send(8'h42, 1'b1, 1'b0);
    cyc(5);
    chk("ovr_valid", {31'd0, urx_valid}, 32'd1);
    chk("ovr_data", {24'd0, urx_data}, 32'h41);
    chk("ovr_pulses", n_ovr, 1);
    urx_ready = 1'b1;
    cyc(20);
    chk("ovr_cleared", {31'd0, urx_valid}, 32'd0);
    chk("ovr_drain", exp_q.size(), 0);

    // Framing error followed by a long break
    ferr0 = n_ferr;
    send(8'h55, 1'b0, 1'b0);
    cyc(50 * DIV);
    chk("brk_ferr", n_ferr - ferr0, 1);
    chk("brk_valid", {31'd0, urx_valid}, 32'd0);
    urx_rxd = 1'b1;
    cyc(DIV);
    send(8'h33, 1'b1, 1'b1);
    cyc(20);
    chk("brk_drain", exp_q.size(), 0);

    // Glitch shorter than half a bit
    ferr0 = n_ferr;
    urx_rxd = 1'b0;
    cyc(2);
    urx_rxd = 1'b1;
    cyc(20);
    chk("glitch_valid", {31'd0, urx_valid}, 32'd0);
    chk("glitch_ferr", n_ferr - ferr0, 0);
    chk("glitch_idle", {29'd0, dut.state}, {29'd0, IDLE});
    send(8'hA5, 1'b1, 1'b1);
    cyc(20);
    chk("glitch_drain", exp_q.size(), 0);

    // Reset during bit 4 of 0xFF, released mid-frame
    fork
      send(8'hFF, 1'b1, 1'b0);
      begin
        cyc(5 * DIV + 3);
        rst_n = 1'b0;
        cyc(1);
        chk("midrst_valid", {31'd0, urx_valid}, 32'd0);
        cyc(2);
        rst_n = 1'b1;
      end
    join
    cyc(2 * DIV);
    chk("midrst_none", {31'd0, urx_valid}, 32'd0);
    send(8'h0F, 1'b1, 1'b1);
    cyc(20);
    chk("midrst_drain", exp_q.size(), 0);
    chk("total_ovr", n_ovr, 1);
    chk("total_ferr", n_ferr, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
